// File: rtl/regfile_loader.sv
// Host-side load/dump sequencer for the 32x32 register file: streams words
// into consecutive registers (LOAD) or reads them back out as a stream (DUMP).
module regfile_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              rf_en,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_da,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_sa,
    input  logic [DATA_W-1:0] rf_a,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD_ADDR,
        RD_OUT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [ADDR_W:0]     remaining, remaining_nxt;
    logic                out_valid_q, out_valid_nxt;
    logic [DATA_W-1:0]   out_data_q, out_data_nxt;

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        out_valid_nxt = out_valid_q;
        out_data_nxt  = out_data_q;
        in_ready      = 1'b0;
        rf_en         = 1'b0;
        rf_rw         = 1'b0;
        rf_da         = '0;
        rf_din        = '0;
        rf_sa         = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt      = base;
                    remaining_nxt = (count == '0) ? CNT_FULL : count;
                    state_nxt     = mode ? RD_ADDR : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                rf_en    = 1'b1;
                rf_rw    = in_valid;
                rf_da    = addr;
                rf_din   = in_data;
                if (in_valid) begin
                    addr_nxt      = addr + ADDR_ONE;
                    remaining_nxt = remaining - CNT_ONE;
                    if (remaining == CNT_ONE) state_nxt = DONE;
                end
            end
            RD_ADDR: begin
                rf_en         = 1'b1;
                rf_sa         = addr;
                out_data_nxt  = rf_a;
                out_valid_nxt = 1'b1;
                state_nxt     = RD_OUT;
            end
            RD_OUT: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    addr_nxt      = addr + ADDR_ONE;
                    remaining_nxt = remaining - CNT_ONE;
                    state_nxt     = (remaining == CNT_ONE) ? DONE : RD_ADDR;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A resetting edge must not accept a word or commit a register write.
        if (!rst) begin
            in_ready = 1'b0;
            rf_en    = 1'b0;
            rf_rw    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            remaining   <= remaining_nxt;
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader with a behavioural 32x32 register file
// and a bench-maintained copy of the contents it should hold.
module tb_regfile_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [4:0]  base;
    logic [5:0]  count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        rf_en;
    logic        rf_rw;
    logic [4:0]  rf_da;
    logic [31:0] rf_din;
    logic [4:0]  rf_sa;
    logic [31:0] rf_a;
    logic        busy;
    logic        done;

    logic        init_mem;
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    int          nw;
    logic [4:0]  wr_da [64];
    int          first_ready;
    int          done_early;
    logic        done_after;
    logic        rw_after;
    logic        busy_after;
    int          nd;
    logic [31:0] dump_buf [64];
    int          first_valid;
    int          dump_cycles;
    int          stab_err;

    regfile_loader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .base      (base),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rf_en     (rf_en),
        .rf_rw     (rf_rw),
        .rf_da     (rf_da),
        .rf_din    (rf_din),
        .rf_sa     (rf_sa),
        .rf_a      (rf_a),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (rf_en && rf_rw) begin
            mem[rf_da] <= rf_din;
        end
    end

    assign rf_a = rf_en ? mem[rf_sa] : 32'h0;

    // Drives one LOAD; optional in_valid gaps and a stray start at cycle 'poke'.
    task automatic run_load(input logic [4:0] b, input logic [5:0] c,
                            input logic [31:0] d0, input bit gaps, input int poke);
        int n, k, cyc;
        n = (c == 6'd0) ? 32 : int'(c);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base = b; count = c;
        @(negedge clk);
        start = 1'b0;
        nw = 0; k = 0; cyc = 0; first_ready = -1; done_early = 0;
        while (k < n && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == poke) begin
                start = 1'b1; mode = 1'b1; base = 5'd0; count = 6'd5;
            end else begin
                start = 1'b0;
            end
            in_valid = !(gaps && (cyc % 3 == 1));
            in_data  = d0 + k;
            #1;
            if (in_ready && first_ready < 0) first_ready = cyc;
            if (done) done_early++;
            if (rf_rw) begin
                if (nw < 64) wr_da[nw] = rf_da;
                nw++;
            end
            if (in_valid && in_ready) k++;
            cyc++;
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        #1;
        done_after = done;
        rw_after   = rf_rw;
        @(negedge clk);
        #1;
        busy_after = busy;
    endtask

    // Drives one DUMP, capturing accepted words and watching hold-stability.
    task automatic run_dump(input logic [4:0] b, input logic [5:0] c, input bit rnd);
        int n, cyc;
        logic prev_stall;
        logic [31:0] prev_data;
        n = (c == 6'd0) ? 32 : int'(c);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base = b; count = c;
        @(negedge clk);
        start = 1'b0;
        nd = 0; cyc = 0; first_valid = -1; stab_err = 0; done_early = 0;
        prev_stall = 1'b0; prev_data = 32'h0;
        while (nd < n && cyc < 1000) begin
            if (cyc > 0) @(negedge clk);
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
            if (done) done_early++;
            if (out_valid && out_ready) begin
                if (nd < 64) dump_buf[nd] = out_data;
                nd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            cyc++;
        end
        dump_cycles = cyc;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        done_after = done;
        @(negedge clk);
        #1;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0; init_mem = 1'b1;
        start = 1'b0; mode = 1'b0; base = 5'd0; count = 6'd0;
        in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h1000_0000 + i;
        repeat (2) @(negedge clk);
        rst = 1'b1; init_mem = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, in_ready, out_valid, rf_en, rf_rw} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {busy, done, in_ready, out_valid, rf_en, rf_rw});
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
        end
        n_checks++;
        if ({rf_da, rf_sa, rf_din} !== 42'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_rf_bus: da %0d sa %0d din %h expected all 0", rf_da, rf_sa, rf_din);
        end
    endtask

    task automatic test_load();
        int bad;
        run_load(5'd3, 6'd4, 32'hA0, 1'b0, -1);
        n_checks++;
        if (nw !== 4) begin n_fail++; $display("[TB] FAIL load_writes: got %0d expected 4", nw); end
        n_checks++;
        if (first_ready !== 0) begin n_fail++; $display("[TB] FAIL load_ready_latency: got %0d expected 0", first_ready); end
        bad = 0;
        for (int i = 0; i < 4; i++) if (wr_da[i] !== 5'(3 + i)) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("[TB] FAIL load_da_order: got %0d wrong indices expected 0", bad); end
        n_checks++;
        if ({done_early != 0, done_after, rw_after, busy_after} !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL load_done_timing: early %0d after %b rw %b busy %b expected 0 1 0 0",
                     done_early, done_after, rw_after, busy_after);
        end
        for (int i = 0; i < 4; i++) ref_mem[3 + i] = 32'hA0 + i;
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("[TB] FAIL load_contents: got %0d differing regs expected 0", bad); end

        run_dump(5'd3, 6'd4, 1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++) if (dump_buf[i] !== 32'hA0 + i) bad++;
        n_checks++;
        if (nd !== 4 || bad != 0) begin
            n_fail++; $display("[TB] FAIL dump_data: got %0d words %0d wrong expected 4 words 0 wrong", nd, bad);
        end
        n_checks++;
        if (first_valid !== 1 || dump_cycles !== 8) begin
            n_fail++;
            $display("[TB] FAIL dump_timing: first_valid %0d cycles %0d expected 1 and 8", first_valid, dump_cycles);
        end
        n_checks++;
        if ({done_early != 0, done_after, busy_after} !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL dump_done_timing: early %0d after %b busy %b expected 0 1 0",
                     done_early, done_after, busy_after);
        end
    endtask

    task automatic test_wrap();
        int bad;
        run_load(5'd30, 6'd3, 32'hB0, 1'b1, -1);
        bad = 0;
        for (int i = 0; i < 3; i++) if (wr_da[i] !== 5'(30 + i)) bad++;
        n_checks++;
        if (nw !== 3 || bad != 0) begin
            n_fail++; $display("[TB] FAIL wrap_load: got %0d writes %0d wrong indices expected 3 and 0", nw, bad);
        end
        ref_mem[30] = 32'hB0; ref_mem[31] = 32'hB1; ref_mem[0] = 32'hB2;
        run_dump(5'd30, 6'd3, 1'b0);
        n_checks++;
        if (nd !== 3 || dump_buf[0] !== 32'hB0 || dump_buf[1] !== 32'hB1 || dump_buf[2] !== 32'hB2) begin
            n_fail++;
            $display("[TB] FAIL wrap_dump: got %0d words %h %h %h expected 3 words b0 b1 b2",
                     nd, dump_buf[0], dump_buf[1], dump_buf[2]);
        end
    endtask

    task automatic test_dump_all();
        int bad;
        run_dump(5'd0, 6'd0, 1'b1);
        bad = 0;
        for (int i = 0; i < 32; i++) if (dump_buf[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (nd !== 32 || bad != 0) begin
            n_fail++; $display("[TB] FAIL dump_all_data: got %0d words %0d wrong expected 32 words 0 wrong", nd, bad);
        end
        n_checks++;
        if (stab_err !== 0) begin n_fail++; $display("[TB] FAIL dump_all_stable: got %0d changes expected 0", stab_err); end
        n_checks++;
        if ({done_after, busy_after} !== 2'b10) begin
            n_fail++; $display("[TB] FAIL dump_all_done: done %b busy %b expected 1 0", done_after, busy_after);
        end
    endtask

    task automatic test_start_ignored();
        int bad;
        run_load(5'd10, 6'd3, 32'hC0, 1'b0, 1);
        bad = 0;
        for (int i = 0; i < 3; i++) if (wr_da[i] !== 5'(10 + i)) bad++;
        n_checks++;
        if (nw !== 3 || bad != 0) begin
            n_fail++; $display("[TB] FAIL busy_start_writes: got %0d writes %0d wrong expected 3 and 0", nw, bad);
        end
        for (int i = 0; i < 3; i++) ref_mem[10 + i] = 32'hC0 + i;
        @(negedge clk);
        #1;
        n_checks++;
        if ({done_after, busy_after, busy, out_valid} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL busy_start_queued: done %b busy %b %b out_valid %b expected 1 0 0 0",
                     done_after, busy_after, busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base = 5'd20; count = 6'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 32'hD0;
        @(negedge clk);
        in_data = 32'hD1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL mid_reset_state: ready %b busy %b done %b expected 0 0 0", in_ready, busy, done);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_done: got %b expected 0", done); end
        ref_mem[20] = 32'hD0; ref_mem[21] = 32'hD1;
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("[TB] FAIL mid_reset_contents: got %0d differing regs expected 0", bad); end

        start = 1'b1; mode = 1'b1; base = 5'd20; count = 6'd2; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hD0) begin
            n_fail++; $display("[TB] FAIL pending_dump: valid %b data %h expected 1 d0", out_valid, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++; $display("[TB] FAIL pending_dump_drop: valid %b busy %b expected 0 0", out_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap();
        test_dump_all();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/regfile_loader.md
# regfile_loader

Load/dump sequencer that sits on the host side of the 32x32 register file. In LOAD mode it accepts a stream of words over a valid/ready handshake and writes them into consecutive registers. In DUMP mode it reads consecutive registers and emits them as a valid/ready output stream. Debug, boot-time initialisation and test harnesses use it to preload or inspect architectural state without going through the datapath.

## Interface
- DATA_W, 32, word width (matches register file data)
- ADDR_W, 5, register index width (2^ADDR_W registers)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- start  in  1  one-cycle request, sampled only in IDLE
- mode  in  1  0 = LOAD, 1 = DUMP; sampled with start
- base  in  ADDR_W  first register index; sampled with start
- count  in  ADDR_W+1  number of words; 0 is treated as 2^ADDR_W; sampled with start
- in_valid / in_ready  in / out  1  load-stream handshake
- in_data  in  DATA_W  load word
- out_valid / out_ready  out / in  1  dump-stream handshake
- out_data  out  DATA_W  dump word
- rf_en  out  1  register file enable
- rf_rw  out  1  register file write strobe
- rf_da  out  ADDR_W  write index
- rf_din  out  DATA_W  write data
- rf_sa  out  ADDR_W  read index
- rf_a  in  DATA_W  read data; combinational from rf_sa while rf_en=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the operation completes

## Operation
- States: IDLE, LOAD, RD_ADDR, RD_OUT, DONE.
- IDLE:
  - start=1 latches base into addr, and count (0→2^ADDR_W) into remaining.
  - Goes to LOAD if mode=0, RD_ADDR if mode=1.
  - start=0 stays in IDLE.
- LOAD:
  - in_ready=1, rf_en=1, rf_rw = in_valid, rf_da = addr, rf_din = in_data (combinational).
  - On in_valid&&in_ready: write happens at that edge, addr+1, remaining−1.
  - If remaining was 1, go to DONE.
- RD_ADDR:
  - rf_en=1, rf_sa = addr.
  - At the next edge, out_data <= rf_a, out_valid <= 1, go to RD_OUT.
- RD_OUT:
  - rf_en=0.
  - Hold out_valid and out_data stable until out_ready.
  - On handshake: out_valid <= 0, addr+1, remaining−1.
  - Go to DONE if remaining was 1, else RD_ADDR.
- DONE: done=1 for exactly one cycle, then IDLE.
- addr arithmetic is modulo 2^ADDR_W: 31+1 wraps to 0.
- Outside LOAD: rf_rw=0, rf_da=0, rf_din=0. Outside RD_ADDR: rf_sa=0.
- start while busy is ignored; no queuing.
- rf_din, rf_da, rf_rw, rf_sa, rf_en are combinational from state/addr. out_data and out_valid are registered.

## Timing
- Reset values: state IDLE, addr 0, remaining 0, out_valid 0, out_data 0, in_ready 0, rf_en 0, rf_rw 0, rf_da 0, rf_din 0, rf_sa 0, busy 0, done 0.
- Reset asserted mid-operation:
  - Returns to IDLE at that edge with no further writes.
  - A pending out_valid is dropped.
  - Registers already written stay written.
- Start to first action:
  - LOAD: in_ready high the cycle after start.
  - DUMP: out_valid high two cycles after start.
- LOAD throughput is 1 word/cycle. in_valid gaps stall without penalty.
- DUMP throughput is 1 word / 2 cycles with out_ready held high.
- done rises the cycle after the final handshake; busy falls the cycle after done.
- A new start is accepted in the cycle busy is low.
- in_ready is 0 in every non-LOAD state. in_valid outside LOAD is ignored.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release -> all outputs 0, busy 0, state IDLE.
- LOAD, base=3, count=4, stream 0xA0..0xA3 with in_valid constant -> rf_rw high 4 cycles, rf_da 3,4,5,6, done one cycle later. A subsequent DUMP of the same range returns 0xA0..0xA3.
- Wrap: LOAD base=30, count=3, then DUMP base=30, count=3 -> writes land at 30,31,0; dump output order matches.
- count=0 DUMP base=0 with random out_ready stalls -> exactly 32 words. Each out_data is stable while out_valid && !out_ready.
- start asserted during an active LOAD -> ignored; mode/base/count unchanged; exactly count writes.
- rst=0 after the 2nd of 4 LOAD words -> only 2 registers changed, in_ready 0 next cycle, no done pulse.
